// File: rtl/lht_update_scheduler.sv
// Arbitrates the single-ported local history table between fetch lookups and
// retire-stage history updates, which are queued and applied as 2-cycle read-modify-writes.
module lht_update_scheduler #(
    parameter int unsigned PC_W         = 10,
    parameter int unsigned IDX_W        = 10,
    parameter int unsigned HIST_W       = 10,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pred_valid,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              pred_ready,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    output logic              upd_ready,
    output logic              lht_en,
    output logic              lht_we,
    output logic [IDX_W-1:0]  lht_addr,
    output logic [HIST_W-1:0] lht_wdata,
    input  logic [HIST_W-1:0] lht_rdata,
    output logic              busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR} state_t;

    state_t             state, next_state;
    logic [IDX_W-1:0]   fifo_idx [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_taken;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [STV_W-1:0]   starve_cnt;
    logic               alive;

    logic               nonempty, full, starve_hit, push, pop;
    logic               starve_inc, starve_clr;
    logic [IDX_W-1:0]   head_idx;
    logic               head_taken;

    assign nonempty   = (count != CNT_W'(0));
    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign starve_hit = (starve_cnt == STV_W'(STARVE_LIMIT));
    // Ready comes from the registered count only, so a same-cycle pop never opens a slot.
    assign upd_ready  = alive & ~full;
    assign push       = upd_valid & upd_ready;
    assign head_idx   = fifo_idx[rd_ptr];
    assign head_taken = fifo_taken[rd_ptr];
    assign busy       = nonempty | (state != IDLE);

    // Goes high on the first clock after reset release; gates every grant and push.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) alive <= 1'b0;
        else        alive <= 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            state <= next_state;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (starve_clr)
                starve_cnt <= '0;
            else if (starve_inc && !starve_hit)
                starve_cnt <= starve_cnt + STV_W'(1);
        end
    end

    // Queue storage needs no reset: count and pointers define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_idx[wr_ptr]   <= upd_pc[IDX_W-1:0];
            fifo_taken[wr_ptr] <= upd_taken;
        end
    end

    always_comb begin
        next_state = state;
        pred_ready = 1'b0;
        lht_en     = 1'b0;
        lht_we     = 1'b0;
        lht_addr   = '0;
        lht_wdata  = '0;
        pop        = 1'b0;
        starve_inc = 1'b0;
        starve_clr = 1'b0;
        case (state)
            IDLE: begin
                if (alive) begin
                    if (pred_valid && !(nonempty && starve_hit)) begin
                        pred_ready = 1'b1;
                        lht_en     = 1'b1;
                        lht_addr   = pred_pc[IDX_W-1:0];
                        starve_inc = nonempty;
                    end else if (nonempty) begin
                        next_state = RMW_RD;
                        starve_clr = 1'b1;
                    end
                end
            end
            RMW_RD: begin
                lht_en     = 1'b1;
                lht_addr   = head_idx;
                next_state = RMW_WR;
            end
            RMW_WR: begin
                lht_en    = 1'b1;
                lht_we    = 1'b1;
                lht_addr  = head_idx;
                lht_wdata = {lht_rdata[HIST_W-2:0], head_taken};
                pop       = 1'b1;
                // Chain straight into the next update when lookups are absent or starved out.
                if (((count > CNT_W'(1)) || push) && (!pred_valid || starve_hit))
                    next_state = RMW_RD;
                else
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
